// File: rtl/bru_redirect_unit_pkg.sv
// Shared definitions for the branch redirect unit: default widths, FSM encoding
// and the correct-next-PC rule.
package bru_redirect_unit_pkg;
  localparam int ROB_IDX_W = 4;
  localparam int CNT_W     = 32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_WAIT_DS  = 2'd1;
  localparam state_t ST_FLUSH    = 2'd2;
  localparam state_t ST_REDIRECT = 2'd3;

  // Not-taken branches resume after the delay slot, hence +8.
  function automatic logic [31:0] correct_pc(input logic        taken,
                                             input logic [31:0] target,
                                             input logic [31:0] pc);
    return taken ? target : pc + 32'd8;
  endfunction
endpackage

// File: rtl/bru_redirect_unit_if.sv
// Bundle between the branch FU / retire / fetch side and the redirect unit.
interface bru_redirect_unit_if #(
  parameter int ROB_IDX_W = bru_redirect_unit_pkg::ROB_IDX_W,
  parameter int CNT_W     = bru_redirect_unit_pkg::CNT_W
);
  logic                 br_valid;
  logic                 br_taken;
  logic [31:0]          br_target;
  logic [31:0]          br_pc;
  logic [ROB_IDX_W-1:0] br_rob_id;
  logic                 pred_taken;
  logic [31:0]          pred_target;
  logic                 ds_retired;
  logic [ROB_IDX_W-1:0] ds_rob_id;
  logic                 fe_ready;

  logic                 bru_stall;
  logic                 flush;
  logic [ROB_IDX_W-1:0] flush_rob_id;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 bp_upd_valid;
  logic [31:0]          bp_upd_pc;
  logic                 bp_upd_taken;
  logic [31:0]          bp_upd_target;
  logic [CNT_W-1:0]     perf_br_cnt;
  logic [CNT_W-1:0]     perf_mis_cnt;

  modport master (
    output br_valid, br_taken, br_target, br_pc, br_rob_id, pred_taken, pred_target,
           ds_retired, ds_rob_id, fe_ready,
    input  bru_stall, flush, flush_rob_id, redirect_valid, redirect_pc, bp_upd_valid,
           bp_upd_pc, bp_upd_taken, bp_upd_target, perf_br_cnt, perf_mis_cnt
  );

  modport slave (
    input  br_valid, br_taken, br_target, br_pc, br_rob_id, pred_taken, pred_target,
           ds_retired, ds_rob_id, fe_ready,
    output bru_stall, flush, flush_rob_id, redirect_valid, redirect_pc, bp_upd_valid,
           bp_upd_pc, bp_upd_taken, bp_upd_target, perf_br_cnt, perf_mis_cnt
  );
endinterface

// File: rtl/bru_perf_cnt.sv
// Branch / mispredict performance counters; wrap naturally at 2**CNT_W.
module bru_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_br_inc,
  input  logic             i_mis_inc,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_mis_cnt
);
  logic [CNT_W-1:0] r_br_cnt, r_mis_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (i_br_inc)  r_br_cnt  <= r_br_cnt + CNT_W'(1);
      if (i_mis_inc) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
    end
  end

  assign o_br_cnt  = r_br_cnt;
  assign o_mis_cnt = r_mis_cnt;
endmodule

// File: rtl/bru_redirect_unit.sv
// Branch resolution check, predictor training and mispredict flush/redirect
// sequencing behind the MIPS delay slot.
module bru_redirect_unit #(
  parameter int ROB_IDX_W = bru_redirect_unit_pkg::ROB_IDX_W,
  parameter int CNT_W     = bru_redirect_unit_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               resetn,
  bru_redirect_unit_if.slave bus
);
  import bru_redirect_unit_pkg::*;

  state_t               r_state, w_nstate;
  logic [31:0]          r_pc, r_target, r_redir_pc;
  logic                 r_taken, r_upd_vld;
  logic [ROB_IDX_W-1:0] r_flush_id;
  logic [ROB_IDX_W-1:0] w_br_ds_id, w_ds_id;
  logic                 w_acc, w_mis, w_ds_hit;

  assign w_acc      = bus.br_valid && (r_state == ST_IDLE);
  assign w_mis      = bus.br_valid && ((bus.br_taken != bus.pred_taken) ||
                      (bus.br_taken && (bus.br_target != bus.pred_target)));
  assign w_br_ds_id = bus.br_rob_id + ROB_IDX_W'(1);
  // In IDLE the delay slot belongs to the incoming branch, later to the latched one.
  assign w_ds_id    = (r_state == ST_IDLE) ? w_br_ds_id : r_flush_id;
  assign w_ds_hit   = bus.ds_retired && (bus.ds_rob_id == w_ds_id);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_IDLE:     if (w_acc && w_mis) w_nstate = w_ds_hit ? ST_FLUSH : ST_WAIT_DS;
      ST_WAIT_DS:  if (w_ds_hit) w_nstate = ST_FLUSH;
      ST_FLUSH:    w_nstate = ST_REDIRECT;
      ST_REDIRECT: if (bus.fe_ready) w_nstate = ST_IDLE;
      default:     w_nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.bru_stall      = (r_state != ST_IDLE);
    bus.flush          = (r_state == ST_FLUSH);
    bus.redirect_valid = (r_state == ST_REDIRECT);
    bus.flush_rob_id   = r_flush_id;
    bus.redirect_pc    = r_redir_pc;
    bus.bp_upd_valid   = r_upd_vld;
    bus.bp_upd_pc      = r_pc;
    bus.bp_upd_taken   = r_taken;
    bus.bp_upd_target  = r_target;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_upd_vld  <= 1'b0;
      r_pc       <= '0;
      r_taken    <= 1'b0;
      r_target   <= '0;
      r_flush_id <= '0;
      r_redir_pc <= '0;
    end else begin
      r_upd_vld <= w_acc;
      if (w_acc) begin
        r_pc       <= bus.br_pc;
        r_taken    <= bus.br_taken;
        r_target   <= bus.br_target;
        r_flush_id <= w_br_ds_id;
        r_redir_pc <= correct_pc(bus.br_taken, bus.br_target, bus.br_pc);
      end
    end
  end

  bru_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk       (clk),
    .resetn    (resetn),
    .i_br_inc  (w_acc),
    .i_mis_inc (w_acc && w_mis),
    .o_br_cnt  (bus.perf_br_cnt),
    .o_mis_cnt (bus.perf_mis_cnt)
  );
endmodule

// File: tb/tb_bru_redirect_unit.sv
// Directed and random bench for bru_redirect_unit against a cycle reference model.
module tb_bru_redirect_unit;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;

  bru_redirect_unit_if #(.ROB_IDX_W(4), .CNT_W(32)) bus ();

  bru_redirect_unit #(.ROB_IDX_W(4), .CNT_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending-mispredict bookkeeping in plain booleans.
  bit          m_wait, m_flush, m_redir, after_rst;
  logic [3:0]  m_fid;
  logic [31:0] m_rpc, e_pc, e_tgt, e_bcnt, e_mcnt;
  logic        e_tk, e_uv;

  task automatic model_edge();
    bit idle, acc, mis, hit, n_wait, n_flush, n_redir;
    if (!resetn) begin
      {m_wait, m_flush, m_redir} = '0;
      m_fid = '0; m_rpc = '0; e_pc = '0; e_tgt = '0; e_tk = 0; e_uv = 0;
      e_bcnt = '0; e_mcnt = '0;
      after_rst = 1;
      return;
    end
    after_rst = 0;
    idle = !(m_wait || m_flush || m_redir);
    acc  = bus.br_valid && idle;
    mis  = (bus.br_taken != bus.pred_taken) || (bus.br_taken && bus.br_target != bus.pred_target);
    n_wait = 0; n_flush = 0; n_redir = 0;
    if (m_redir && !bus.fe_ready) n_redir = 1;
    if (m_flush) n_redir = 1;
    if (m_wait) begin
      if (bus.ds_retired && bus.ds_rob_id == m_fid) n_flush = 1;
      else n_wait = 1;
    end
    e_uv = acc;
    if (acc) begin
      e_pc = bus.br_pc; e_tk = bus.br_taken; e_tgt = bus.br_target;
      e_bcnt = e_bcnt + 1;
      if (mis) begin
        e_mcnt = e_mcnt + 1;
        m_fid  = bus.br_rob_id + 4'd1;
        m_rpc  = bus.br_taken ? bus.br_target : bus.br_pc + 32'd8;
        if (bus.ds_retired && bus.ds_rob_id == m_fid) n_flush = 1;
        else n_wait = 1;
      end
    end
    m_wait = n_wait; m_flush = n_flush; m_redir = n_redir;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("stall",     32'(bus.bru_stall),      32'(m_wait || m_flush || m_redir));
    check("flush",     32'(bus.flush),          32'(m_flush));
    check("redir_vld", 32'(bus.redirect_valid), 32'(m_redir));
    check("upd_vld",   32'(bus.bp_upd_valid),   32'(e_uv));
    check("br_cnt",    bus.perf_br_cnt,         e_bcnt);
    check("mis_cnt",   bus.perf_mis_cnt,        e_mcnt);
    if (m_flush || after_rst) check("flush_id", 32'(bus.flush_rob_id), 32'(m_fid));
    if (m_redir || after_rst) check("redir_pc", bus.redirect_pc, m_rpc);
    if (e_uv || after_rst) begin
      check("upd_pc",  bus.bp_upd_pc,         e_pc);
      check("upd_tk",  32'(bus.bp_upd_taken), 32'(e_tk));
      check("upd_tgt", bus.bp_upd_target,     e_tgt);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic quiet();
    bus.br_valid = 0; bus.br_taken = 0; bus.br_target = '0; bus.br_pc = '0;
    bus.br_rob_id = '0; bus.pred_taken = 0; bus.pred_target = '0;
    bus.ds_retired = 0; bus.ds_rob_id = '0; bus.fe_ready = 1;
  endtask

  task automatic branch(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt, input logic [3:0] id);
    bus.br_valid = 1; bus.br_pc = pc; bus.br_taken = tk; bus.br_target = tgt;
    bus.pred_taken = ptk; bus.pred_target = ptgt; bus.br_rob_id = id;
  endtask

  initial begin
    logic [31:0] saved_b, saved_m;
    quiet();
    resetn = 0;
    cyc();
    cyc();
    resetn = 1;

    // correct prediction
    branch(32'h100, 1, 32'h1000, 1, 32'h1000, 4'd1);
    cyc();
    quiet();
    check("t1_tgt", bus.bp_upd_target, 32'h1000);
    check("t1_cnt", bus.perf_br_cnt, 32'd1);
    cyc();

    // direction mispredict, delay slot retires two cycles later
    branch(32'h400, 0, 32'h0, 1, 32'h800, 4'd3);
    cyc();
    quiet();
    cyc();
    bus.ds_retired = 1; bus.ds_rob_id = 4'd4;
    cyc();
    quiet();
    check("t2_flush_id", 32'(bus.flush_rob_id), 32'd4);
    cyc();
    check("t2_redir_pc", bus.redirect_pc, 32'h408);
    cyc();

    // target mispredict at rob 15, delay slot id 0 retiring in the same cycle
    branch(32'h500, 1, 32'h2000, 1, 32'h3000, 4'd15);
    bus.ds_retired = 1; bus.ds_rob_id = 4'd0;
    cyc();
    quiet();
    bus.fe_ready = 0;
    check("t3_flush", 32'(bus.flush), 32'd1);
    check("t3_flush_id", 32'(bus.flush_rob_id), 32'd0);
    // fetch stalls the redirect for 5 cycles
    repeat (5) begin
      cyc();
      check("t4_redir_pc", bus.redirect_pc, 32'h2000);
    end
    bus.fe_ready = 1;
    cyc();
    check("t4_idle", 32'(bus.bru_stall), 32'd0);

    // wrong-path branch while waiting for the delay slot
    branch(32'h600, 1, 32'h4000, 0, 32'h0, 4'd6);
    cyc();
    saved_b = bus.perf_br_cnt; saved_m = bus.perf_mis_cnt;
    branch(32'h700, 1, 32'h9000, 0, 32'h0, 4'd9);
    cyc();
    quiet();
    check("t5_br_cnt", bus.perf_br_cnt, saved_b);
    check("t5_mis_cnt", bus.perf_mis_cnt, saved_m);
    bus.ds_retired = 1; bus.ds_rob_id = 4'd7;
    cyc();
    quiet();
    cyc();
    check("t5_redir_pc", bus.redirect_pc, 32'h4000);
    cyc();

    // reset while waiting for the delay slot
    branch(32'h800, 0, 32'h0, 1, 32'hA00, 4'd2);
    cyc();
    quiet();
    resetn = 0;
    cyc();
    check("t6_stall", 32'(bus.bru_stall), 32'd0);
    resetn = 1;
    bus.ds_retired = 1; bus.ds_rob_id = 4'd3;
    repeat (4) cyc();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      bus.br_valid    = ($urandom_range(0, 2) == 0);
      bus.br_taken    = $urandom_range(0, 1) == 1;
      bus.pred_taken  = $urandom_range(0, 1) == 1;
      bus.br_target   = 32'h1000 + 32'($urandom_range(0, 1)) * 32'h10;
      bus.pred_target = 32'h1000 + 32'($urandom_range(0, 1)) * 32'h10;
      bus.br_pc       = $urandom & 32'hFFFF_FFFC;
      bus.br_rob_id   = 4'($urandom_range(0, 3)) - 4'd1;
      bus.ds_retired  = $urandom_range(0, 1) == 1;
      bus.ds_rob_id   = 4'($urandom_range(0, 3));
      bus.fe_ready    = $urandom_range(0, 2) != 0;
      resetn          = ($urandom_range(0, 199) != 0);
      cyc();
    end
    resetn = 1;
    quiet();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
